// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between pipeline writeback (always wins)
// and a small FIFO of multiply/divide results; tracks pending writes in a busy scoreboard.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK_WbArb,
  input  logic        RST_WbArb,
  input  logic        Pipe_WE,
  input  logic [4:0]  Pipe_A3,
  input  logic [31:0] Pipe_WD,
  input  logic        MD_Issue,
  input  logic [4:0]  MD_Issue_Rd,
  input  logic        MD_Valid,
  input  logic [4:0]  MD_A3,
  input  logic [31:0] MD_WD,
  output logic        MD_Ready,
  input  logic [4:0]  Chk_A1,
  input  logic [4:0]  Chk_A2,
  input  logic [4:0]  Chk_A3,
  output logic        Hazard_Stall,
  output logic        RF_WE3,
  output logic [4:0]  RF_A3,
  output logic [31:0] RF_WD3,
  output logic [31:0] Busy_Vec,
  output logic        Ovf_Err,
  output logic        Waw_Err
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fifo_a3 [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wd [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    count_nxt;
  logic              md_ready_q;
  logic [31:0]       busy_q;
  logic [31:0]       busy_nxt;
  logic              ovf_q;
  logic              waw_q;

  logic              pipe_wr;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              stall;
  logic              issue_set;
  logic [ADDR_W-1:0] head_a3;
  logic [DATA_W-1:0] head_wd;

  assign head_a3    = fifo_a3[rd_ptr];
  assign head_wd    = fifo_wd[rd_ptr];
  assign pipe_wr    = Pipe_WE && (Pipe_A3 != '0);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign push       = MD_Valid && !fifo_full;
  // Head pops even when its address is r0, so r0 results simply evaporate.
  assign pop        = !pipe_wr && !fifo_empty;

  assign stall = busy_q[Chk_A1] || busy_q[Chk_A2] || busy_q[Chk_A3] ||
                 (MD_Issue && busy_q[MD_Issue_Rd]);
  assign issue_set = MD_Issue && (MD_Issue_Rd != '0) && !stall;

  assign Hazard_Stall = !RST_WbArb && stall;
  assign MD_Ready     = md_ready_q;
  assign Busy_Vec     = busy_q;
  assign Ovf_Err      = ovf_q;
  assign Waw_Err      = waw_q;

  always_comb begin
    RF_WE3 = 1'b0;
    RF_A3  = '0;
    RF_WD3 = '0;
    if (!RST_WbArb) begin
      if (pipe_wr) begin
        RF_WE3 = 1'b1;
        RF_A3  = Pipe_A3;
        RF_WD3 = Pipe_WD;
      end else if (!fifo_empty) begin
        RF_WE3 = (head_a3 != '0);
        RF_A3  = head_a3;
        RF_WD3 = head_wd;
      end
    end
  end

  // A coincident set wins over a drain clear of the same register.
  always_comb begin
    busy_nxt = busy_q;
    if (pop)       busy_nxt[head_a3]     = 1'b0;
    if (issue_set) busy_nxt[MD_Issue_Rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // MD_Ready is held low through reset and rises on the first edge after release.
  always_ff @(posedge CLK_WbArb or posedge RST_WbArb) begin
    if (RST_WbArb) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      md_ready_q <= 1'b0;
      busy_q     <= '0;
      ovf_q      <= 1'b0;
      waw_q      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      md_ready_q <= (count_nxt != FULL_CNT);
      busy_q     <= busy_nxt;
      if (MD_Valid && fifo_full)       ovf_q <= 1'b1;
      if (pipe_wr && busy_q[Pipe_A3])  waw_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK_WbArb) begin
    if (push) begin
      fifo_a3[wr_ptr] <= MD_A3;
      fifo_wd[wr_ptr] <= MD_WD;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: priority, full FIFO, scoreboard, WAW, reset, r0.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        Pipe_WE;
  logic [4:0]  Pipe_A3;
  logic [31:0] Pipe_WD;
  logic        MD_Issue;
  logic [4:0]  MD_Issue_Rd;
  logic        MD_Valid;
  logic [4:0]  MD_A3;
  logic [31:0] MD_WD;
  logic        MD_Ready;
  logic [4:0]  Chk_A1, Chk_A2, Chk_A3;
  logic        Hazard_Stall;
  logic        RF_WE3;
  logic [4:0]  RF_A3;
  logic [31:0] RF_WD3;
  logic [31:0] Busy_Vec;
  logic        Ovf_Err;
  logic        Waw_Err;

  int errors = 0;
  int checks = 0;

  regfile_write_arbiter #(.FIFO_DEPTH(4)) dut (
    .CLK_WbArb(clk), .RST_WbArb(rst),
    .Pipe_WE(Pipe_WE), .Pipe_A3(Pipe_A3), .Pipe_WD(Pipe_WD),
    .MD_Issue(MD_Issue), .MD_Issue_Rd(MD_Issue_Rd),
    .MD_Valid(MD_Valid), .MD_A3(MD_A3), .MD_WD(MD_WD), .MD_Ready(MD_Ready),
    .Chk_A1(Chk_A1), .Chk_A2(Chk_A2), .Chk_A3(Chk_A3), .Hazard_Stall(Hazard_Stall),
    .RF_WE3(RF_WE3), .RF_A3(RF_A3), .RF_WD3(RF_WD3),
    .Busy_Vec(Busy_Vec), .Ovf_Err(Ovf_Err), .Waw_Err(Waw_Err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    Pipe_WE = 1'b1; Pipe_A3 = 5'd3; Pipe_WD = 32'hdead;
    MD_Issue = 1'b0; MD_Issue_Rd = '0;
    MD_Valid = 1'b0; MD_A3 = '0; MD_WD = '0;
    Chk_A1 = '0; Chk_A2 = '0; Chk_A3 = '0;

    // reset: outputs quiet, pipeline ignored
    #2;
    chk("rst_we", RF_WE3, 0);
    chk("rst_a3", RF_A3, 0);
    chk("rst_wd", RF_WD3, 0);
    chk("rst_ready", MD_Ready, 0);
    chk("rst_busy", Busy_Vec, 0);
    chk("rst_stall", Hazard_Stall, 0);
    tick(); tick();
    rst = 1'b0; Pipe_WE = 1'b0;
    tick();
    chk("rel_ready", MD_Ready, 1);
    chk("rel_ovf", Ovf_Err, 0);

    // pipeline priority over a queued result
    MD_Issue = 1'b1; MD_Issue_Rd = 5'd7;
    #1 chk("iss7_stall", Hazard_Stall, 0);
    tick();
    MD_Issue = 1'b0;
    chk("iss7_busy", Busy_Vec, 32'h80);
    MD_Valid = 1'b1; MD_A3 = 5'd7; MD_WD = 32'h22;
    #1 chk("nobypass_we", RF_WE3, 0);
    tick();
    MD_Valid = 1'b0;
    Pipe_WE = 1'b1; Pipe_A3 = 5'd5; Pipe_WD = 32'h11;
    #1;
    chk("pri_we", RF_WE3, 1);
    chk("pri_a3", RF_A3, 5);
    chk("pri_wd", RF_WD3, 32'h11);
    tick();
    Pipe_WE = 1'b0;
    #1;
    chk("drain7_we", RF_WE3, 1);
    chk("drain7_a3", RF_A3, 7);
    chk("drain7_wd", RF_WD3, 32'h22);
    tick();
    chk("clr7_busy", Busy_Vec, 0);
    chk("idle_we", RF_WE3, 0);
    chk("idle_waw", Waw_Err, 0);

    // WAW: pipeline writes busy r4
    MD_Issue = 1'b1; MD_Issue_Rd = 5'd4;
    tick();
    MD_Issue = 1'b0;
    Pipe_WE = 1'b1; Pipe_A3 = 5'd4; Pipe_WD = 32'h44;
    #1 chk("waw_we", RF_WE3, 1);
    tick();
    Pipe_WE = 1'b0;
    chk("waw_err", Waw_Err, 1);
    chk("waw_busy", Busy_Vec, 32'h10);

    // scoreboard stall on r9
    MD_Issue = 1'b1; MD_Issue_Rd = 5'd9;
    tick();
    MD_Issue = 1'b0;
    Chk_A1 = 5'd9;
    #1 chk("st9_a1", Hazard_Stall, 1);
    Chk_A1 = 5'd0;
    #1 chk("st0_a1", Hazard_Stall, 0);
    MD_Issue = 1'b1; MD_Issue_Rd = 5'd9;
    #1 chk("st9_issue", Hazard_Stall, 1);
    MD_Issue = 1'b0;
    Chk_A1 = 5'd9;
    MD_Valid = 1'b1; MD_A3 = 5'd9; MD_WD = 32'h99;
    tick();
    MD_Valid = 1'b0;
    #1;
    chk("st9_draincyc", Hazard_Stall, 1);
    chk("drain9_a3", RF_A3, 9);
    tick();
    chk("st9_after", Hazard_Stall, 0);
    chk("clr9_busy", Busy_Vec, 32'h10);
    Chk_A1 = 5'd0;

    // full FIFO under constant pipeline traffic
    Pipe_WE = 1'b1; Pipe_A3 = 5'd1; Pipe_WD = 32'h1;
    MD_Valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      MD_A3 = 5'(10 + i); MD_WD = 32'hA0 + 32'(i);
      #1;
      chk("full_ready", MD_Ready, (i < 4) ? 1 : 0);
      chk("full_pipe_a3", RF_A3, 1);
      tick();
    end
    MD_Valid = 1'b0;
    chk("full_ovf", Ovf_Err, 1);
    chk("full_ready_end", MD_Ready, 0);
    Pipe_WE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("order_we", RF_WE3, 1);
      chk("order_a3", RF_A3, 10 + i);
      chk("order_wd", RF_WD3, 32'hA0 + 32'(i));
      tick();
    end
    chk("empty_we", RF_WE3, 0);
    chk("empty_ready", MD_Ready, 1);

    // register 0 traffic
    MD_Valid = 1'b1; MD_A3 = 5'd0; MD_WD = 32'h55;
    tick();
    MD_Valid = 1'b0;
    #1 chk("r0_drain_we", RF_WE3, 0);
    tick();
    chk("r0_busy", Busy_Vec, 32'h10);
    MD_Issue = 1'b1; MD_Issue_Rd = 5'd0;
    tick();
    MD_Issue = 1'b0;
    chk("r0_issue_busy", Busy_Vec, 32'h10);
    Pipe_WE = 1'b1; Pipe_A3 = 5'd0; Pipe_WD = 32'h77;
    #1 chk("r0_pipe_we", RF_WE3, 0);
    Pipe_WE = 1'b0;

    // reset mid-drain with three queued entries
    MD_Issue = 1'b1; MD_Issue_Rd = 5'd20;
    tick();
    MD_Issue = 1'b0;
    Pipe_WE = 1'b1; Pipe_A3 = 5'd2; Pipe_WD = 32'h2;
    MD_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      MD_A3 = 5'(20 + i); MD_WD = 32'hC0 + 32'(i);
      tick();
    end
    MD_Valid = 1'b0; Pipe_WE = 1'b0;
    #1;
    chk("pre_rst_we", RF_WE3, 1);
    chk("pre_rst_a3", RF_A3, 20);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", RF_WE3, 0);
    chk("mid_rst_busy", Busy_Vec, 0);
    chk("mid_rst_ready", MD_Ready, 0);
    chk("mid_rst_ovf", Ovf_Err, 0);
    chk("mid_rst_waw", Waw_Err, 0);
    #2 rst = 1'b0;
    tick();
    chk("post_rst_ready", MD_Ready, 1);
    chk("post_rst_we0", RF_WE3, 0);
    tick();
    chk("post_rst_we1", RF_WE3, 0);
    chk("post_rst_busy", Busy_Vec, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The parameter list SHALL be: FIFO_DEPTH, 4, number of multi-cycle result entries held (power of two, 2..16).
REQ-002 The ports SHALL be (name, direction, width, meaning), with clock and reset first:
- CLK_WbArb, in, 1: the single clock.
- RST_WbArb, in, 1: asynchronous, active-high reset.
- Pipe_WE, in, 1: pipeline writeback write request.
- Pipe_A3, in, 5: pipeline destination register.
- Pipe_WD, in, 32: pipeline write data.
- MD_Issue, in, 1: multiply/divide op issued this cycle.
- MD_Issue_Rd, in, 5: destination of the issued op.
- MD_Valid, in, 1: multiply/divide result valid.
- MD_A3, in, 5: destination of the result.
- MD_WD, in, 32: result data.
- MD_Ready, out, 1: result buffer can accept.
- Chk_A1, Chk_A2, Chk_A3, in, 5 each: decode-stage source and destination registers.
- Hazard_Stall, out, 1: decode SHALL stall.
- RF_WE3, out, 1: register file write enable.
- RF_A3, out, 5: register file write address.
- RF_WD3, out, 32: register file write data.
- Busy_Vec, out, 32: pending-write scoreboard.
- Ovf_Err, out, 1: sticky error, result dropped.
- Waw_Err, out, 1: sticky error, pipeline wrote a busy register.
REQ-003 The clock SHALL be the single clock, and reset SHALL be asynchronous and active-high, as stated for CLK_WbArb and RST_WbArb.

Function
REQ-004 The block SHALL share the register file's single write port between the pipeline writeback and a FIFO of multi-cycle results.
- Pipeline priority: the pipeline SHALL always have priority.
- No backpressure: the pipeline SHALL never be backpressured.
REQ-005 When Pipe_WE=1 and Pipe_A3!=0, the write SHALL pass combinationally in the same cycle.
- Outputs: RF_WE3=1, RF_A3=Pipe_A3, RF_WD3=Pipe_WD.
REQ-006 When Pipe_WE=0, or Pipe_A3=0, and the FIFO is non-empty, the FIFO head SHALL drain.
- Outputs: RF_WE3=(head addr!=0), RF_A3=head addr, RF_WD3=head data.
- Pop: the head SHALL be popped at the rising edge.
REQ-007 When there is no pipeline write and the FIFO is empty, outputs SHALL be RF_WE3=0, RF_A3=0 and RF_WD3=0.
REQ-008 The enqueue rule SHALL be: MD_Valid=1 with count<FIFO_DEPTH pushes {MD_A3, MD_WD} at the rising edge.
- Minimum latency: 1 cycle from MD_Valid to RF_WE3.
- No bypass: there SHALL be no same-cycle bypass.
REQ-009 A simultaneous push and pop SHALL leave the count unchanged, and FIFO order SHALL be preserved.
- Pointer wrap: pointers SHALL wrap modulo FIFO_DEPTH.
REQ-010 MD_Ready SHALL be (count<FIFO_DEPTH).
- Timing: it SHALL be registered state and SHALL NOT depend on a same-cycle pop.
REQ-011 When MD_Valid=1 and the FIFO is full, the result SHALL be discarded.
- Error flag: Ovf_Err SHALL be set and SHALL remain set until reset.
- Unchanged state: count and Busy_Vec SHALL be unaffected.
REQ-012 Scoreboard set: Busy_Vec[r] SHALL be set at the edge where MD_Issue=1, MD_Issue_Rd=r, r!=0 and Hazard_Stall=0.
REQ-013 Scoreboard clear: Busy_Vec[r] SHALL be cleared at the edge where a FIFO entry with address r drains.
- Priority: if a set and a clear of the same r coincide, the set SHALL win.
REQ-014 Busy_Vec[0] SHALL always be 0.
- Register-0 traffic: writes and issues to register 0 SHALL never assert RF_WE3 and SHALL never set a busy bit.
REQ-015 Hazard_Stall SHALL be combinational and SHALL be 1 when any of the following holds:
- Busy_Vec[Chk_A1]=1.
- Busy_Vec[Chk_A2]=1.
- Busy_Vec[Chk_A3]=1.
- MD_Issue=1 and Busy_Vec[MD_Issue_Rd]=1.
REQ-016 A pipeline write to a register whose busy bit is set SHALL still be performed.
- Error flag: Waw_Err SHALL be set (sticky).
- Busy bit: the busy bit SHALL be unchanged.
REQ-017 MD_Valid for a register whose busy bit is clear SHALL be enqueued and written normally.

Reset
REQ-018 While RST_WbArb=1, the block SHALL hold the following reset values, asynchronously:
- FIFO and pointers: count=0, pointers=0.
- Scoreboard: Busy_Vec=0.
- Error flags: Ovf_Err=0, Waw_Err=0.
- Handshake and stall: MD_Ready=0, Hazard_Stall=0.
- Write port: RF_WE3=0, RF_A3=0, RF_WD3=0.
- Pipeline inputs: pipeline inputs SHALL be ignored.
REQ-019 FIFO contents SHALL be discarded by reset, including when reset is asserted mid-drain.
- After release: MD_Ready=1 at the first rising edge after release.

Verification
REQ-020 Pipeline priority: Pipe_WE=1, Pipe_A3=5, Pipe_WD=0x11, with the FIFO holding {7, 0x22} -> RF_A3=5 and WD 0x11 that cycle; {7, 0x22} written the next idle cycle; Busy_Vec[7] cleared.
REQ-021 Full FIFO: 5 MD_Valid pushes with Pipe_WE held at 1 -> MD_Ready=0 after the 4th push; 5th result dropped; Ovf_Err=1; 4 writes drain in order once Pipe_WE=0.
REQ-022 Scoreboard stall: MD_Issue with Rd=9, then Chk_A1=9 -> Hazard_Stall=1 until the cycle after the r9 drain, then 0; Chk_A1=0 never stalls.
REQ-023 WAW error: Busy_Vec[4]=1, then Pipe_WE with A3=4 -> RF_WE3=1, Waw_Err=1, Busy_Vec[4] still 1.
REQ-024 Reset mid-operation: FIFO count 3, assert RST_WbArb mid-cycle -> RF_WE3=0 immediately; after release, no stale writes, Busy_Vec=0, MD_Ready=1.
REQ-025 Register 0: MD_Valid with MD_A3=0 -> the entry drains with RF_WE3=0; Busy_Vec unchanged.
